// File: rtl/odd_par_serializer.sv
// odd_par_serializer: 16-bit word to serial frame (start, 16 data LSB first, odd parity, stop)
// Ports: clk, rst (async active-high); data_in/valid_in accept a word when ready_out=1;
//        tx serial line (idle high); busy = ~ready_out; parity = odd parity of last accepted word;
//        done pulses for the first idle cycle after a stop bit.
module odd_par_serializer #(
  parameter int BAUD_DIV = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] data_in,
  input  logic        valid_in,
  output logic        ready_out,
  output logic        tx,
  output logic        busy,
  output logic        parity,
  output logic        done
);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  localparam logic [7:0] LAST = 8'(BAUD_DIV - 1);
  state_t state, state_n;
  logic [7:0] baud, baud_n;
  logic [3:0] bitc, bitc_n;
  logic [15:0] sh, sh_n;
  logic par_n, tx_n, done_n, bit_end;
  assign bit_end = baud == LAST;
  assign ready_out = state == IDLE;
  assign busy = ~ready_out;
  // tx_n holds the level for the next bit so tx changes only on bit boundaries
  always_comb begin
    state_n = state;
    baud_n = (state == IDLE || bit_end) ? 8'd0 : baud + 8'd1;
    bitc_n = bitc;
    sh_n = sh;
    par_n = parity;
    tx_n = tx;
    done_n = 1'b0;
    case (state)
      IDLE: if (valid_in) begin
        state_n = START;
        sh_n = data_in;
        par_n = ~^data_in;
        tx_n = 1'b0;
      end
      START: if (bit_end) begin
        state_n = DATA;
        tx_n = sh[0];
      end
      DATA: if (bit_end) begin
        sh_n = sh >> 1;
        bitc_n = bitc + 4'd1;
        state_n = (bitc == 4'd15) ? PARITY : DATA;
        tx_n = (bitc == 4'd15) ? parity : sh[1];
      end
      PARITY: if (bit_end) begin
        state_n = STOP;
        tx_n = 1'b1;
      end
      STOP: if (bit_end) begin
        state_n = IDLE;
        done_n = 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      baud <= '0;
      bitc <= '0;
      sh <= '0;
      parity <= 1'b0;
      tx <= 1'b1;
      done <= 1'b0;
    end else begin
      state <= state_n;
      baud <= baud_n;
      bitc <= bitc_n;
      sh <= sh_n;
      parity <= par_n;
      tx <= tx_n;
      done <= done_n;
    end
  end
endmodule

// File: doc/odd_par_serializer.md
ODD_PAR_SERIALIZER -- requirements
Module: odd_par_serializer

Interface
REQ-001 SHALL have parameter BAUD_DIV, default 4: clock cycles per transmitted bit; legal range 1..255.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port data_in  input  16  word to transmit; sampled only on acceptance.
REQ-005 SHALL have port valid_in  input  1  data_in is valid this cycle.
REQ-006 SHALL have port ready_out  output  1  block can accept a word this cycle.
REQ-007 SHALL have port tx  output  1  serial line; idle level high.
REQ-008 SHALL have port busy  output  1  a frame is in progress.
REQ-009 SHALL have port parity  output  1  odd-parity bit of the last accepted word.
REQ-010 SHALL have port done  output  1  one-cycle pulse marking frame completion.

Function
REQ-011 SHALL implement states IDLE, START, DATA, PARITY, STOP; state is held in a register.
REQ-012 SHALL drive ready_out = 1 exactly when in IDLE; busy SHALL be its complement.
REQ-013 SHALL accept a word on a rising edge where valid_in = 1 and ready_out = 1, latching data_in into a 16-bit shift register.
REQ-014 SHALL, on acceptance, latch parity = inverted XOR-reduction of data_in, so the 17 bits {data, parity} contain an odd number of ones.
REQ-015 SHALL ignore valid_in and data_in changes while busy = 1; the frame in flight is unaffected.
REQ-016 SHALL transition IDLE->START on acceptance; tx = 0 starting the cycle after acceptance.
REQ-017 SHALL hold each bit on tx for exactly BAUD_DIV cycles, counted by a baud counter that runs 0..BAUD_DIV-1 and clears on each bit boundary.
REQ-018 SHALL go START->DATA after BAUD_DIV cycles, then transmit data bits LSB first (bit 0 to bit 15), tracked by a 4-bit bit counter.
REQ-019 SHALL go DATA->PARITY after bit 15 completes; tx = latched parity for BAUD_DIV cycles.
REQ-020 SHALL go PARITY->STOP; tx = 1 for BAUD_DIV cycles; then STOP->IDLE.
REQ-021 SHALL assert done for exactly the first IDLE cycle after STOP; done SHALL be 0 at all other times.
REQ-022 SHALL give a frame length of 19*BAUD_DIV cycles from the first START cycle to the last STOP cycle.
REQ-023 SHALL allow back-to-back frames: a word accepted in the done cycle starts START on the next cycle, leaving one idle cycle (tx = 1) between frames.
REQ-024 SHALL register tx; tx SHALL be glitch-free and change only on bit boundaries.
REQ-025 SHALL behave correctly with BAUD_DIV = 1, one cycle per bit.

Reset
REQ-026 SHALL, while rst = 1 and independently of clk, force the state to IDLE, tx = 1, ready_out = 1, busy = 0, done = 0, parity = 0, and clear both counters and the shift register.
REQ-027 SHALL abort any frame in progress when rst asserts mid-frame; tx returns high immediately and no done pulse is produced.
REQ-028 SHALL accept a word on the first rising edge after rst deasserts if valid_in = 1.

Verification
REQ-029 SHALL cover: BAUD_DIV=4, data_in=16'h576B accepted -> parity=1; tx sequence over 76 cycles is 0, then 1,1,0,1, 0,1,1,0, 1,1,1,0, 1,0,1,0, then 1 (parity), then 1 (stop); each bit lasts 4 cycles; done pulses once.
REQ-030 SHALL cover parity corner values: 16'h0000 -> parity 1; 16'hFFFF -> parity 1; 16'h0001 -> parity 0; 16'h8000 -> parity 0; each checked on the tx parity bit.
REQ-031 SHALL cover back-to-back frames: valid_in held high with 16'hA5A5 then 16'h3C3C -> the second START begins exactly 2 cycles after the last STOP cycle of the first frame, and ready_out = 1 only in the done cycle.
REQ-032 SHALL cover mid-frame reset: rst pulsed during DATA bit 7 -> tx = 1 and ready_out = 1 immediately, no done pulse, and a new word 16'h1234 is then sent correctly.
REQ-033 SHALL cover ignored input: valid_in toggled with data_in = 16'hFFFF during a 16'h0F0F frame -> the transmitted frame is 16'h0F0F with parity 1, and no second frame starts.
REQ-034 SHALL cover BAUD_DIV=1 with data_in=16'h8001 -> 19-cycle frame, parity = 1, tx bit 0 = 1, bit 15 = 1.
